// File: rtl/clock_rate_meter_defs.sv
// Shared state encoding and legal-range constants for clock_rate_meter and its synchronizer.
package clock_rate_meter_defs;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  localparam int unsigned MIN_TIMEOUT_CYCLES = 32'd2;
  localparam int unsigned MIN_SYNC_STAGES    = 32'd2;

endpackage

// File: rtl/edge_synchronizer.sv
// Multi-flop synchronizer plus history flop for a slow asynchronous input;
// emits a one-cycle pulse on each synchronized rising edge.
module edge_synchronizer
  import clock_rate_meter_defs::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  if (SyncStages < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("edge_synchronizer: SyncStages must be at least %0d", MIN_SYNC_STAGES);
  end

  logic [SyncStages-1:0] r_sync;
  logic                  r_hist;

  // Shift the raw input through the synchronizer chain, then into the history flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], i_async};
      r_hist <= r_sync[SyncStages-1];
    end
  end

  assign o_rise = r_sync[SyncStages-1] & ~r_hist;

endmodule

// File: rtl/clock_rate_meter.sv
// Measures the period of a slow asynchronous clock in local cycles, with stall and overrun flags.
// Optional period_min/period_max tracking is enabled by defining CLOCK_RATE_METER_MINMAX_EN.
module clock_rate_meter
  import clock_rate_meter_defs::*;
#(
  parameter int unsigned Width         = 32,
  parameter int unsigned TimeoutCycles = 32'h01FF_FFFF,
  parameter int unsigned SyncStages    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inclock,
  input  logic             clear,
  output logic [Width-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             stalled,
  output logic             overrun
`ifdef CLOCK_RATE_METER_MINMAX_EN
  ,
  output logic [Width-1:0] period_min,
  output logic [Width-1:0] period_max
`endif
);

  if (TimeoutCycles < MIN_TIMEOUT_CYCLES) begin : g_bad_timeout_low
    $error("clock_rate_meter: TimeoutCycles must be at least %0d", MIN_TIMEOUT_CYCLES);
  end
  if ((64'(TimeoutCycles) >> Width) != 64'd0) begin : g_bad_timeout_high
    $error("clock_rate_meter: TimeoutCycles must fit in Width bits");
  end

  localparam logic [Width:0] TIMEOUT_CNT = (Width+1)'(TimeoutCycles);

  meter_state_t     r_state, w_state_nxt;
  logic [Width-1:0] r_cnt, w_cnt_nxt, w_cnt_sat;
  logic [Width:0]   w_cnt_inc;
  logic [Width-1:0] r_period;
  logic             r_valid, r_stalled, r_overrun;
  logic             w_rise, w_new_result, w_stall_set, w_load, w_drop;

  edge_synchronizer #(
    .SyncStages(SyncStages)
  ) u_edge_sync (
    .i_clk  (clock),
    .i_rst_n(reset),
    .i_async(inclock),
    .o_rise (w_rise)
  );

  assign w_cnt_inc = {1'b0, r_cnt} + {{Width{1'b0}}, 1'b1};
  assign w_cnt_sat = w_cnt_inc[Width] ? {Width{1'b1}} : w_cnt_inc[Width-1:0];

  // Measurement state and period counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // An edge always takes precedence over a timeout landing in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_new_result = 1'b0;
    w_stall_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          w_new_result = 1'b1;
          w_cnt_nxt    = '0;
        end else if (w_cnt_inc == TIMEOUT_CNT) begin
          w_stall_set = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_sat;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_load = w_new_result & (~r_valid | period_ready);
  assign w_drop = w_new_result & r_valid & ~period_ready;

  // Single-entry result buffer plus sticky flags; a set event beats a same-cycle clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_stalled <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_period <= w_cnt_sat;
        r_valid  <= 1'b1;
      end else if (r_valid && period_ready) begin
        r_valid <= 1'b0;
      end
      r_stalled <= w_stall_set | (r_stalled & ~clear);
      r_overrun <= w_drop | (r_overrun & ~clear);
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign stalled      = r_stalled;
  assign overrun      = r_overrun;

`ifdef CLOCK_RATE_METER_MINMAX_EN
  logic [Width-1:0] r_min, r_max, w_min_base, w_max_base;

  assign w_min_base = clear ? {Width{1'b1}} : r_min;
  assign w_max_base = clear ? {Width{1'b0}} : r_max;

  // Extremes track every completed result, dropped ones included; clear restarts tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_min <= {Width{1'b1}};
      r_max <= {Width{1'b0}};
    end else if (w_new_result) begin
      r_min <= (w_cnt_sat < w_min_base) ? w_cnt_sat : w_min_base;
      r_max <= (w_cnt_sat > w_max_base) ? w_cnt_sat : w_max_base;
    end else begin
      r_min <= w_min_base;
      r_max <= w_max_base;
    end
  end

  assign period_min = r_min;
  assign period_max = r_max;
`endif

endmodule

// File: tb/tb_clock_rate_meter.sv
// Randomized scoreboard bench for clock_rate_meter against a time-stamp based reference model.
`timescale 1ns/1ps
module tb_clock_rate_meter;

  localparam int W = 32;
  localparam int T = 100;
  localparam int S = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic         inclock;
  logic         clear;
  logic         period_ready;
  logic [W-1:0] period;
  logic         period_valid;
  logic         stalled;
  logic         overrun;
`ifdef CLOCK_RATE_METER_MINMAX_EN
  logic [W-1:0] period_min;
  logic [W-1:0] period_max;
`endif

  clock_rate_meter #(
    .Width(W), .TimeoutCycles(T), .SyncStages(S)
  ) dut (
    .clock(clock), .reset(reset), .inclock(inclock), .clear(clear),
    .period(period), .period_valid(period_valid), .period_ready(period_ready),
    .stalled(stalled), .overrun(overrun)
`ifdef CLOCK_RATE_METER_MINMAX_EN
    , .period_min(period_min), .period_max(period_max)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // Reference model: rising-edge time stamps and a one-slot output channel.
  longint          m_cyc;
  bit              m_prev_inc;
  longint          m_pend[$];
  bit              m_meas;
  longint          m_last;
  bit              m_valid, m_stalled, m_overrun;
  longint unsigned exp_q[$];
  longint unsigned m_min, m_max;

  bit inc_state;
  int hp_left;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    exp_q.delete();
    m_prev_inc = 1'b0;
    m_meas = 1'b0;
    m_last = 0;
    m_valid = 1'b0;
    m_stalled = 1'b0;
    m_overrun = 1'b0;
    m_min = 64'h0000_0000_FFFF_FFFF;
    m_max = 0;
  endtask

  task automatic model_step();
    bit det = 1'b0, newr = 1'b0, stall = 1'b0, ovf = 1'b0;
    longint res = 0;
    m_cyc++;
    if (inclock && !m_prev_inc) m_pend.push_back(m_cyc + S);
    m_prev_inc = inclock;
    if (m_pend.size() > 0 && m_pend[0] == m_cyc) begin
      det = 1'b1;
      void'(m_pend.pop_front());
    end
    if (det) begin
      if (m_meas) begin
        newr = 1'b1;
        res = m_cyc - m_last;
      end
      m_meas = 1'b1;
      m_last = m_cyc;
    end else if (m_meas && (m_cyc - m_last == T)) begin
      stall = 1'b1;
      m_meas = 1'b0;
    end
    if (clear) begin
      m_min = 64'h0000_0000_FFFF_FFFF;
      m_max = 0;
    end
    if (newr) begin
      if (!m_valid || period_ready) begin
        exp_q.push_back(res);
        m_valid = 1'b1;
      end else begin
        ovf = 1'b1;
      end
      if (res < m_min) m_min = res;
      if (res > m_max) m_max = res;
    end else if (m_valid && period_ready) begin
      m_valid = 1'b0;
    end
    m_stalled = stall | (m_stalled & !clear);
    m_overrun = ovf | (m_overrun & !clear);
  endtask

  task automatic cyc(input bit inc, input bit rdy, input bit clr);
    @(posedge clock);
    #1;
    model_step();
    inclock = inc;
    period_ready = rdy;
    clear = clr;
  endtask

  task automatic run(input int n, input int hp_min, input int hp_max,
                     input int rdy_pct, input int clr_pct, input bit stop);
    for (int i = 0; i < n; i++) begin
      if (!stop) begin
        if (hp_left <= 0) begin
          inc_state = !inc_state;
          hp_left = $urandom_range(hp_max, hp_min);
        end
        hp_left--;
      end
      cyc(inc_state, $urandom_range(99, 0) < rdy_pct, $urandom_range(99, 0) < clr_pct);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_valid"}, period_valid, 0);
    check({tag, "_stalled"}, stalled, 0);
    check({tag, "_overrun"}, overrun, 0);
`ifdef CLOCK_RATE_METER_MINMAX_EN
    check({tag, "_min"}, period_min, 64'h0000_0000_FFFF_FFFF);
    check({tag, "_max"}, period_max, 0);
`endif
  endtask

  // Monitor: compares flags every cycle and pops the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        check("valid", period_valid, m_valid);
        check("stalled", stalled, m_stalled);
        check("overrun", overrun, m_overrun);
`ifdef CLOCK_RATE_METER_MINMAX_EN
        check("period_min", period_min, m_min);
        check("period_max", period_max, m_max);
`endif
        if (period_valid && period_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0d expected none", period);
          end else begin
            check("period", period, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    inclock = 1'b0;
    clear = 1'b0;
    period_ready = 1'b0;
    inc_state = 1'b0;
    hp_left = $urandom_range(7, 0);
    m_cyc = 0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    #30;
    reset = 1'b1;
    mon_en = 1'b1;

    run(400, 8, 8, 20, 0, 0);
    run(120, 8, 8, 0, 0, 0);
    run(1, 8, 8, 0, 100, 0);
    run(60, 8, 8, 100, 0, 0);
    run(60, 10, 10, 50, 0, 0);
    run(220, 10, 10, 50, 0, 1);
    run(120, 10, 10, 50, 0, 0);
    run(400, 50, 50, 100, 0, 0);
    run(600, 50, 51, 60, 0, 0);
    run(600, 2, 4, 50, 0, 0);
    run(3000, 2, 60, 50, 2, 0);
    run(37, 6, 9, 30, 0, 0);

    @(posedge clock);
    #3;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    model_reset();
    mon_en = 1'b1;
    run(400, 5, 15, 50, 0, 0);

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
